dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single data-memory port (word addr, 32b wdata, 4b byteen, combinational rdata) between
//  M0 (CPU M-stage data port) and M1 (secondary master: DMA/debug loader). Single-cycle grants;
//  round-robin on contention; optional M1 burst lock. Sits between CPU/bridge and DM.
// PARAMETERS
//  DM_WORDS   4096  DM depth in 32b words; byte addr >= DM_WORDS*4 is out of range
//  MAX_BURST  8     max consecutive locked grants to one master (1..255)
//  CNT_W      16    width of conflict_cnt
// PORTS
//  clk           in   1     clock, all state on posedge
//  reset         in   1     asynchronous, active-low reset
//  m0_req        in   1     M0 access request (held until granted)
//  m0_addr       in   32    M0 byte address
//  m0_wdata      in   32    M0 write data (byte lanes pre-aligned)
//  m0_byteen     in   4     M0 byte enables; 4'b0000 = read
//  m0_gnt        out  1     M0 access performed this cycle
//  m0_rdata      out  32    read data, valid when m0_gnt
//  m0_err        out  1     M0 granted access was out of range
//  m1_req/m1_addr/m1_wdata/m1_byteen/m1_gnt/m1_rdata/m1_err   same as M0, for M1
//  m1_lock       in   1     M1 requests to keep ownership after this grant
//  mem_addr      out  32    word-aligned DM address {addr[31:2],2'b00}
//  mem_wdata     out  32    DM write data
//  mem_byteen    out  4     DM byte enables; write commits at posedge
//  mem_rdata     in   32    DM combinational read data
//  conflict_cnt  out  CNT_W saturating count of cycles with m0_req & m1_req
// BEHAVIOUR
//  - Grants are combinational in the request cycle; access completes at the closing posedge.
//    Master updates req/addr at that edge. Zero added latency when uncontended.
//  - Registered state: fsm {IDLE, LOCK1}, rr_ptr (0 = M0 preferred), burst_cnt (8b), conflict_cnt.
//  - IDLE: only one req -> grant it. Both -> grant rr_ptr side. After any grant rr_ptr <= other master.
//  - LOCK1: m1_gnt = m1_req; M0 denied. Exit to IDLE when m1_req=0, m1_lock=0, or
//    burst_cnt reaches MAX_BURST (forced release: rr_ptr <= 0, M0 wins next contention).
//  - IDLE->LOCK1 when m1_gnt & m1_lock; burst_cnt <= 1 on entry, +1 per locked grant, 0 in IDLE.
//  - Exactly one of m0_gnt/m1_gnt high per cycle; never a gnt without matching req.
//  - No grant: mem_byteen=0, mem_addr=0, mem_wdata=0. mX_rdata = mem_rdata when mX_gnt, else 0.
//  - Out of range (addr[31:2] >= DM_WORDS): grant still issued, mem_byteen forced 0,
//    rdata 0, mX_err=1 in that cycle. addr[1:0] ignored (no misalign check here).
//  - conflict_cnt +1 each cycle with both reqs (incl. lock-denied cycles); holds at all-ones.
//  - Reset (async, any cycle incl. mid-burst): fsm=IDLE, rr_ptr=0, burst_cnt=0, conflict_cnt=0;
//    outputs are combinational on req and follow from this state; pending writes not committed.
// CONFIGURATION
//  DMARB_LOCK_EN defined: m1_lock honoured, LOCK1 state and burst_cnt present as above.
//  DMARB_LOCK_EN undefined: m1_lock ignored, fsm stays IDLE, burst_cnt removed; pure round-robin.
// TESTING
//  1 Reset low then high; m0 write addr 0x10, wdata 0x12345678, be 4'hF alone -> m0_gnt same cycle,
//    mem_addr=0x10, mem_byteen=4'hF; read back 0x10 -> m0_rdata=0x12345678.
//  2 Both req continuously from reset, 4 cycles -> grants M0,M1,M0,M1; conflict_cnt=4.
//  3 (LOCK_EN) M1 req+lock held 12 cycles, M0 req held -> M1 granted 8 cycles, then M0 1 cycle,
//    then M1 again; without DMARB_LOCK_EN -> strict alternation.
//  4 M0 write addr 0x4000 (DM_WORDS=4096), be 4'h3 -> m0_gnt=1, m0_err=1, mem_byteen=0;
//    DM unchanged.
//  5 Assert reset in cycle 3 of an M1 lock burst -> fsm IDLE, rr_ptr=0, conflict_cnt=0;
//    after release both req -> M0 granted first.
//  6 Force conflict for 2^CNT_W+5 cycles -> conflict_cnt saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between M0 (CPU data
// port) and M1 (DMA / debug loader). Grants are combinational in the request
// cycle, round-robin on contention, with an optional M1 burst lock.
// Optional feature macro: DMARB_LOCK_EN (enables m1_lock, LOCK1 state, burst_cnt).
module dm_port_arbiter #(
    parameter int unsigned DM_WORDS  = 4096,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_byteen,
    output logic             m0_gnt,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_byteen,
    input  logic             m1_lock,
    output logic             m1_gnt,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [30:0] DM_WORDS_W = 31'(DM_WORDS);

    logic             rr_ptr_q, rr_ptr_d;      // 0 = M0 preferred on contention
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
    logic             idle_m0, idle_m1;         // plain round-robin decision
    logic             contended;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       sel_byteen;
    logic             any_gnt, in_range;

    // Low address bits are dropped by word alignment; misalignment is checked upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    assign contended    = m0_req & m1_req;
    assign conflict_cnt = conflict_cnt_q;

    // Round-robin choice used whenever no burst lock is held
    always_comb begin
        idle_m0 = m0_req & (~m1_req | ~rr_ptr_q);
        idle_m1 = m1_req & (~m0_req |  rr_ptr_q);
    end

`ifdef DMARB_LOCK_EN
    typedef enum logic {IDLE, LOCK1} state_t;

    localparam logic [8:0] MAX_B        = 9'(MAX_BURST);
    // With a one-grant limit a burst would end on the grant that opened it.
    localparam bit         LOCK_ALLOWED = (MAX_BURST > 1);

    state_t     state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [8:0] burst_next;

    assign burst_next = {1'b0, burst_cnt_q} + 9'd1;

    // Grant: M1 owns the port outright while locked, otherwise round-robin
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (state_q == LOCK1) begin
            m1_gnt = m1_req;
        end else begin
            m0_gnt = idle_m0;
            m1_gnt = idle_m1;
        end
    end

    // Next state, burst length and round-robin pointer
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (m0_gnt) begin
            rr_ptr_d = 1'b1;
        end else if (m1_gnt) begin
            rr_ptr_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                burst_cnt_d = 8'd0;
                if (m1_gnt && m1_lock && LOCK_ALLOWED) begin
                    state_d     = LOCK1;
                    burst_cnt_d = 8'd1;
                end
            end
            LOCK1: begin
                if (!m1_req || !m1_lock) begin
                    state_d     = IDLE;
                    burst_cnt_d = 8'd0;
                end else if (burst_next >= MAX_B) begin
                    // Forced release: M0 wins the next contention.
                    state_d     = IDLE;
                    burst_cnt_d = 8'd0;
                    rr_ptr_d    = 1'b0;
                end else begin
                    burst_cnt_d = burst_next[7:0];
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Lock FSM and burst length registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    // Without the lock feature m1_lock has no effect.
    logic unused_lock;
    assign unused_lock = m1_lock;

    // Grant: pure round-robin
    always_comb begin
        m0_gnt = idle_m0;
        m1_gnt = idle_m1;
    end

    // Round-robin pointer flips to the other master after every grant
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (m0_gnt) begin
            rr_ptr_d = 1'b1;
        end else if (m1_gnt) begin
            rr_ptr_d = 1'b0;
        end
    end
`endif

    // Saturating contention counter
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (contended && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Memory port mux, range check and read-data steering
    always_comb begin
        sel_addr   = m1_gnt ? m1_addr   : m0_addr;
        sel_wdata  = m1_gnt ? m1_wdata  : m0_wdata;
        sel_byteen = m1_gnt ? m1_byteen : m0_byteen;
        any_gnt    = m0_gnt | m1_gnt;
        in_range   = ({1'b0, sel_addr[31:2]} < DM_WORDS_W);

        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_byteen = 4'd0;
        if (any_gnt) begin
            mem_addr   = {sel_addr[31:2], 2'b00};
            mem_wdata  = sel_wdata;
            // Out-of-range accesses are still granted but never reach the array.
            mem_byteen = in_range ? sel_byteen : 4'd0;
        end

        m0_rdata = (m0_gnt && in_range) ? mem_rdata : 32'd0;
        m1_rdata = (m1_gnt && in_range) ? mem_rdata : 32'd0;
        m0_err   = m0_gnt & ~in_range;
        m1_err   = m1_gnt & ~in_range;
    end

    // Round-robin pointer and contention counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q       <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a behavioural
// 4096-word data memory (combinational read, byte-lane write at posedge).
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_dm_port_arbiter;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             m0_req, m1_req, m1_lock;
    logic [31:0]      m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]       m0_byteen, m1_byteen;
    logic             m0_gnt, m1_gnt, m0_err, m1_err;
    logic [31:0]      m0_rdata, m1_rdata;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_byteen;
    logic [CNT_W-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] dm [4096];
    logic [11:0] dm_idx;
    logic        tb_unused;

    dm_port_arbiter #(.DM_WORDS(4096), .MAX_BURST(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DM; the index aliases above 4096 words so a leaked write is visible.
    assign dm_idx    = mem_addr[13:2];
    assign tb_unused = ^{mem_addr[31:14], mem_addr[1:0]};
    assign mem_rdata = dm[dm_idx];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_byteen[i]) dm[dm_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_byteen = 4'd0;
        m1_req = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_byteen = 4'd0;
        m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        advance();
        advance();
        reset = 1'b1;
    endtask

    initial begin
        logic [11:0] exp_m1;

        for (int i = 0; i < 4096; i++) dm[i] = 32'd0;
        reset = 1'b0;
        idle_inputs();
        advance();

        // Reset state with nobody requesting
        do_reset();
        settle();
        check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        check("rst_mem_byteen", 32'(mem_byteen), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_conflict", 32'(conflict_cnt), 32'h0);

        // 1: lone M0 write then read back
        m0_req = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h12345678; m0_byteen = 4'hF;
        settle();
        check("t1_wr_gnt", 32'({m0_gnt, m1_gnt}), 32'h2);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_byteen", 32'(mem_byteen), 32'hF);
        check("t1_mem_wdata", mem_wdata, 32'h12345678);
        advance();
        m0_byteen = 4'h0; m0_wdata = 32'd0;
        settle();
        check("t1_rd_gnt", 32'(m0_gnt), 32'h1);
        check("t1_rd_data", m0_rdata, 32'h12345678);
        advance();

        // M1 partial write to same word (addr[1:0] ignored), then M1 read back
        idle_inputs();
        m1_req = 1'b1; m1_addr = 32'h13; m1_wdata = 32'hFFFFAAAA; m1_byteen = 4'h3;
        settle();
        check("m1_wr_gnt", 32'({m0_gnt, m1_gnt}), 32'h1);
        check("m1_wr_addr", mem_addr, 32'h10);
        advance();
        m1_byteen = 4'h0;
        settle();
        check("m1_rd_data", m1_rdata, 32'h1234AAAA);
        check("m0_rdata_idle", m0_rdata, 32'h0);
        advance();

        // M1 writes word 0 so the aliasing test below can detect leaks
        m1_addr = 32'h0; m1_wdata = 32'hA5A5A5A5; m1_byteen = 4'hF;
        advance();
        idle_inputs();

        // 4: out-of-range M0 write and read
        m0_req = 1'b1; m0_addr = 32'h4000; m0_wdata = 32'hDEADBEEF; m0_byteen = 4'h3;
        settle();
        check("t4_gnt", 32'(m0_gnt), 32'h1);
        check("t4_err", 32'(m0_err), 32'h1);
        check("t4_byteen", 32'(mem_byteen), 32'h0);
        advance();
        m0_byteen = 4'h0;
        settle();
        check("t4_rd_err", 32'(m0_err), 32'h1);
        check("t4_rd_data", m0_rdata, 32'h0);
        advance();
        m0_addr = 32'h0;
        settle();
        check("t4_dm_unchanged", m0_rdata, 32'hA5A5A5A5);
        check("t4_inrange_err", 32'(m0_err), 32'h0);
        advance();

        // 2: both request from reset
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t2_gnt%0d", i), 32'({m0_gnt, m1_gnt}), (i % 2 == 0) ? 32'h2 : 32'h1);
            check($sformatf("t2_cnt%0d", i), 32'(conflict_cnt), 32'(i));
            advance();
        end
        settle();
        check("t2_conflict", 32'(conflict_cnt), 32'h4);

        // 3: M1 lock burst against a persistent M0 (rr_ptr set to M1 first)
        do_reset();
        m0_req = 1'b1;
        advance();
        m1_req = 1'b1; m1_lock = 1'b1;
`ifdef DMARB_LOCK_EN
        exp_m1 = 12'b1110_1111_1111;
`else
        exp_m1 = 12'b0101_0101_0101;
`endif
        for (int i = 0; i < 12; i++) begin
            settle();
            check($sformatf("t3_gnt%0d", i), 32'({m0_gnt, m1_gnt}),
                  exp_m1[i] ? 32'h1 : 32'h2);
            advance();
        end

        // 5: reset asserted in cycle 3 of an M1 burst
        do_reset();
        m0_req = 1'b1;
        advance();
        m1_req = 1'b1; m1_lock = 1'b1;
        settle();
        check("t5_c1", 32'({m0_gnt, m1_gnt}), 32'h1);
        advance();
        settle();
`ifdef DMARB_LOCK_EN
        check("t5_c2", 32'({m0_gnt, m1_gnt}), 32'h1);
`else
        check("t5_c2", 32'({m0_gnt, m1_gnt}), 32'h2);
`endif
        advance();
        reset = 1'b0;
        settle();
        check("t5_rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h2);
        check("t5_rst_cnt", 32'(conflict_cnt), 32'h0);
        advance();
        reset = 1'b1;
        settle();
        check("t5_after_gnt", 32'({m0_gnt, m1_gnt}), 32'h2);
        check("t5_after_cnt", 32'(conflict_cnt), 32'h0);
        advance();

        // 6: conflict counter saturation
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (65534) advance();
        settle();
        check("t6_pre_sat", 32'(conflict_cnt), 32'hFFFE);
        repeat (7) advance();
        settle();
        check("t6_sat", 32'(conflict_cnt), 32'hFFFF);
        check("t6_still_gnt", 32'(m0_gnt ^ m1_gnt), 32'h1);

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
